// File: rtl/cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cache_pkg                                                    |
// | Purpose  : Shared types and constants for the cache port arbiter.       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package cache_pkg;

  // Width of the access latency down-counter (latencies up to 15 cycles).
  localparam int CNT_W = 4;

  // Mux select encodings.
  localparam logic SEL_PROC1 = 1'b0;
  localparam logic SEL_PROC2 = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cache_arbiter                                                |
// | Purpose  : Round-robin sequencer for the shared cache port. Drives the  |
// |            mux select and cache enable, and pulses a one-cycle Ack to   |
// |            the winning processor once its access latency has elapsed.   |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic proc1_Req,
  input  logic proc2_Req,
  input  logic proc1_WE,
  input  logic proc2_WE,
  output logic sel,
  output logic cache_En,
  output logic proc1_Ack,
  output logic proc2_Ack,
  output logic busy
);

  // Counter load values: the grant cycle itself counts as the first cycle.
  localparam logic [CNT_W-1:0] c_rd_load = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] c_wr_load = CNT_W'(WRITE_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_last;
  logic             w_sel;
  logic             w_en;
  logic             w_ack1;
  logic             w_ack2;
  logic             w_busy;
  logic             w_win;
  logic             w_we;

  // Next-state and next-output logic; every output is then registered so
  // nothing reaches a port combinationally from Req or WE.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_last  = r_last;
    w_sel   = sel;
    w_en    = 1'b0;
    w_ack1  = 1'b0;
    w_ack2  = 1'b0;
    w_win   = r_last;
    w_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (proc1_Req || proc2_Req) begin
          // On a tie the processor that did not win last time gets the port.
          if (proc1_Req && proc2_Req) w_win = ~r_last;
          else                        w_win = proc2_Req ? SEL_PROC2 : SEL_PROC1;
          // WE is captured only here; later changes cannot alter latency.
          w_we    = (w_win == SEL_PROC2) ? proc2_WE : proc1_WE;
          w_sel   = w_win;
          w_last  = w_win;
          w_cnt   = w_we ? c_wr_load : c_rd_load;
          w_en    = 1'b1;
          w_state = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CNT_W'(1);
          w_en  = 1'b1;
        end else begin
          // Ack goes to whoever owns the frozen select, even if Req dropped.
          w_ack1  = (sel == SEL_PROC1);
          w_ack2  = (sel == SEL_PROC2);
          w_state = DONE;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= SEL_PROC2;
      sel       <= SEL_PROC1;
      cache_En  <= 1'b0;
      proc1_Ack <= 1'b0;
      proc2_Ack <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_last    <= w_last;
      sel       <= w_sel;
      cache_En  <= w_en;
      proc1_Ack <= w_ack1;
      proc2_Ack <= w_ack2;
      busy      <= w_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_cache_arbiter                                             |
// | Purpose  : Directed self-checking bench for cache_arbiter, with a small |
// |            behavioural cache mux on the data side.                      |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_cache_arbiter;
  import cache_pkg::*;

  logic clk;
  logic rst_n;
  logic proc1_Req, proc2_Req, proc1_WE, proc2_WE;
  logic sel, cache_En, proc1_Ack, proc2_Ack, busy;

  logic [15:0] cache_dout;
  logic [15:0] proc1_dout;
  logic [15:0] proc2_dout;

  int total;
  int bad;

  cache_arbiter #(.READ_LAT(2), .WRITE_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .proc1_Req (proc1_Req),
    .proc2_Req (proc2_Req),
    .proc1_WE  (proc1_WE),
    .proc2_WE  (proc2_WE),
    .sel       (sel),
    .cache_En  (cache_En),
    .proc1_Ack (proc1_Ack),
    .proc2_Ack (proc2_Ack),
    .busy      (busy)
  );

  // Behavioural cache mux returning read data to the selected processor.
  assign cache_dout = 16'hf0f0;
  assign proc1_dout = (sel == SEL_PROC1) ? cache_dout : 16'h0000;
  assign proc2_dout = (sel == SEL_PROC2) ? cache_dout : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; proc1_Req = 1'b1; proc2_Req = 1'b1; proc1_WE = 1'b0; proc2_WE = 1'b0;
    repeat (3) tick;
    total++; if (sel !== 1'b0)       begin bad++; $display("FAIL rst_sel got=%b exp=0", sel); end
    total++; if (cache_En !== 1'b0)  begin bad++; $display("FAIL rst_en got=%b exp=0", cache_En); end
    total++; if (proc1_Ack !== 1'b0) begin bad++; $display("FAIL rst_ack1 got=%b exp=0", proc1_Ack); end
    total++; if (proc2_Ack !== 1'b0) begin bad++; $display("FAIL rst_ack2 got=%b exp=0", proc2_Ack); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    tick;
    total++; if (sel !== 1'b0)      begin bad++; $display("FAIL rst_first_sel got=%b exp=0", sel); end
    total++; if (cache_En !== 1'b1) begin bad++; $display("FAIL rst_first_en got=%b exp=1", cache_En); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL rst_first_busy got=%b exp=1", busy); end
    tick; tick;
    total++; if (proc1_Ack !== 1'b1 || proc2_Ack !== 1'b0)
      begin bad++; $display("FAIL rst_first_ack got=%b%b exp=10", proc1_Ack, proc2_Ack); end
    proc1_Req = 1'b0; proc2_Req = 1'b0;
    tick; tick;
  endtask

  task automatic test_single_read;
    logic [4:0] exp_en;
    logic [4:0] exp_ack;
    exp_en  = 5'b00011;   // bit i = cycle i+1
    exp_ack = 5'b00100;
    proc1_Req = 1'b1; proc1_WE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++; if (cache_En !== exp_en[i])
        begin bad++; $display("FAIL read_en cyc=%0d got=%b exp=%b", i + 1, cache_En, exp_en[i]); end
      total++; if (proc1_Ack !== exp_ack[i])
        begin bad++; $display("FAIL read_ack cyc=%0d got=%b exp=%b", i + 1, proc1_Ack, exp_ack[i]); end
      total++; if (sel !== 1'b0)
        begin bad++; $display("FAIL read_sel cyc=%0d got=%b exp=0", i + 1, sel); end
      if (i == 2) begin
        total++; if (proc1_dout !== 16'hf0f0)
          begin bad++; $display("FAIL read_data got=%h exp=f0f0", proc1_dout); end
        proc1_Req = 1'b0;
      end
    end
  endtask

  task automatic test_single_write;
    logic [3:0] exp_en;
    logic [3:0] exp_ack;
    exp_en  = 4'b0001;
    exp_ack = 4'b0010;
    proc2_Req = 1'b1; proc2_WE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (cache_En !== exp_en[i])
        begin bad++; $display("FAIL write_en cyc=%0d got=%b exp=%b", i + 1, cache_En, exp_en[i]); end
      total++; if (proc2_Ack !== exp_ack[i] || proc1_Ack !== 1'b0)
        begin bad++; $display("FAIL write_ack cyc=%0d got=%b%b exp=0%b", i + 1, proc1_Ack, proc2_Ack, exp_ack[i]); end
      total++; if (sel !== 1'b1)
        begin bad++; $display("FAIL write_sel cyc=%0d got=%b exp=1", i + 1, sel); end
      if (i == 1) proc2_Req = 1'b0;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_idle_busy got=%b exp=0", busy); end
    proc2_WE = 1'b0;
  endtask

  task automatic test_contention;
    int n;
    int prev;
    bit re1;
    bit re2;
    n = 0; prev = 0; re1 = 1'b0; re2 = 1'b0;
    proc1_Req = 1'b1; proc2_Req = 1'b1; proc1_WE = 1'b0; proc2_WE = 1'b0;
    for (int c = 1; c <= 24 && n < 4; c++) begin
      tick;
      if (re1) begin proc1_Req = 1'b1; re1 = 1'b0; end
      if (re2) begin proc2_Req = 1'b1; re2 = 1'b0; end
      if (proc1_Ack || proc2_Ack) begin
        n++;
        total++;
        if ((n % 2) == 1) begin
          if (proc1_Ack !== 1'b1 || proc2_Ack !== 1'b0)
            begin bad++; $display("FAIL cont_order n=%0d got=%b%b exp=10", n, proc1_Ack, proc2_Ack); end
        end else begin
          if (proc1_Ack !== 1'b0 || proc2_Ack !== 1'b1)
            begin bad++; $display("FAIL cont_order n=%0d got=%b%b exp=01", n, proc1_Ack, proc2_Ack); end
        end
        total++;
        if (n == 1) begin
          if (c != 3) begin bad++; $display("FAIL cont_first cyc got=%0d exp=3", c); end
        end else if (c - prev != 4) begin
          bad++; $display("FAIL cont_spacing n=%0d got=%0d exp=4", n, c - prev);
        end
        prev = c;
        if (proc1_Ack) begin proc1_Req = 1'b0; re1 = 1'b1; end
        if (proc2_Ack) begin proc2_Req = 1'b0; re2 = 1'b1; end
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL cont_count got=%0d exp=4", n); end
    proc1_Req = 1'b0; proc2_Req = 1'b0;
    tick; tick;
  endtask

  task automatic test_reset_mid;
    proc2_Req = 1'b1; proc2_WE = 1'b0;
    tick; tick;
    total++; if (sel !== 1'b1 || cache_En !== 1'b1)
      begin bad++; $display("FAIL mid_pre got sel=%b en=%b exp sel=1 en=1", sel, cache_En); end
    rst_n = 1'b0;
    tick;
    total++; if (sel !== 1'b0)       begin bad++; $display("FAIL mid_sel got=%b exp=0", sel); end
    total++; if (cache_En !== 1'b0)  begin bad++; $display("FAIL mid_en got=%b exp=0", cache_En); end
    total++; if (proc2_Ack !== 1'b0) begin bad++; $display("FAIL mid_ack got=%b exp=0", proc2_Ack); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    proc2_Req = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++; if (proc2_Ack !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL mid_after cyc=%0d got ack=%b busy=%b exp 0 0", i, proc2_Ack, busy); end
    end
    proc1_Req = 1'b1; proc2_Req = 1'b1;
    tick;
    total++; if (sel !== 1'b0 || cache_En !== 1'b1)
      begin bad++; $display("FAIL mid_regrant got sel=%b en=%b exp sel=0 en=1", sel, cache_En); end
    tick; tick;
    total++; if (proc1_Ack !== 1'b1)
      begin bad++; $display("FAIL mid_regrant_ack got=%b exp=1", proc1_Ack); end
    proc1_Req = 1'b0; proc2_Req = 1'b0;
    tick; tick;
  endtask

  task automatic test_we_change;
    // Read granted, then Req drops and WE rises: still a 2-cycle access.
    proc1_Req = 1'b1; proc1_WE = 1'b0;
    tick;
    total++; if (cache_En !== 1'b1) begin bad++; $display("FAIL we_rd_en1 got=%b exp=1", cache_En); end
    proc1_Req = 1'b0; proc1_WE = 1'b1;
    tick;
    total++; if (cache_En !== 1'b1 || proc1_Ack !== 1'b0)
      begin bad++; $display("FAIL we_rd_c2 got en=%b ack=%b exp en=1 ack=0", cache_En, proc1_Ack); end
    tick;
    total++; if (cache_En !== 1'b0 || proc1_Ack !== 1'b1)
      begin bad++; $display("FAIL we_rd_c3 got en=%b ack=%b exp en=0 ack=1", cache_En, proc1_Ack); end
    tick;
    total++; if (proc1_Ack !== 1'b0) begin bad++; $display("FAIL we_rd_once got=%b exp=0", proc1_Ack); end
    tick;
    total++; if (busy !== 1'b0 || cache_En !== 1'b0)
      begin bad++; $display("FAIL we_rd_idle got busy=%b en=%b exp 0 0", busy, cache_En); end
    proc1_WE = 1'b0;
    // Write granted, then WE falls: still a 1-cycle access.
    proc2_Req = 1'b1; proc2_WE = 1'b1;
    tick;
    proc2_Req = 1'b0; proc2_WE = 1'b0;
    tick;
    total++; if (cache_En !== 1'b0 || proc2_Ack !== 1'b1)
      begin bad++; $display("FAIL we_wr_c2 got en=%b ack=%b exp en=0 ack=1", cache_En, proc2_Ack); end
    tick; tick;
    total++; if (busy !== 1'b0 || proc2_Ack !== 1'b0)
      begin bad++; $display("FAIL we_wr_idle got busy=%b ack=%b exp 0 0", busy, proc2_Ack); end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; proc1_Req = 1'b0; proc2_Req = 1'b0; proc1_WE = 1'b0; proc2_WE = 1'b0;
    test_reset;
    test_single_read;
    test_single_write;
    test_contention;
    test_reset_mid;
    test_we_change;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
